// File: rtl/i2c_init_sequencer_if.sv
// ----------------------------------------------------------------------------
// i2c_init_sequencer_if
//   Link between the init sequencer and the I2C register-write engine. The
//   sequencer is the Avalon-MM master for the engine's slave port
//   (0 = iCall, 1 = iAddr, 2 = iData). The engine returns a one-cycle done
//   pulse for each completed write.
//
//   avm_chipselect  master -> slave  chipselect
//   avm_write       master -> slave  single-cycle write strobe (no waitrequest)
//   avm_address     master -> slave  register address
//   avm_writedata   master -> slave  write data
//   i2c_done        slave  -> master engine done pulse (isDone)
// ----------------------------------------------------------------------------
interface i2c_init_sequencer_if;
    logic        avm_chipselect;
    logic        avm_write;
    logic [7:0]  avm_address;
    logic [31:0] avm_writedata;
    logic        i2c_done;

    modport master (
        output avm_chipselect,
        output avm_write,
        output avm_address,
        output avm_writedata,
        input  i2c_done
    );

    modport slave (
        input  avm_chipselect,
        input  avm_write,
        input  avm_address,
        input  avm_writedata,
        output i2c_done
    );
endinterface

// File: rtl/i2c_init_sequencer.sv
// ----------------------------------------------------------------------------
// i2c_init_sequencer
//   Power-up/config sequencer for the I2C register-write engine. On start it
//   walks a table of {reg_addr, data} pairs and issues one engine write per
//   entry: iAddr, iData, iCall=2, wait for the engine's done pulse, then clear
//   iCall. Engine writes that never complete (slave NACKs forever) are cut
//   off by a timeout.
//
//   CLOCK        in   system clock
//   RESET        in   synchronous active-high reset
//   start        in   one-cycle pulse: run the table from entry 0
//   tbl_count    in   number of valid entries, sampled on start (clamped to 2**AW)
//   tbl_index    out  table read address
//   tbl_data     in   combinational table read: [15:8] reg addr, [7:0] data
//   bus          --   Avalon master to the engine plus its done pulse
//   busy         out  high from the cycle after start is accepted through FINISH
//   done         out  one-cycle pulse when the sequence ends
//   error        out  sticky timeout flag; cleared on accepted start or RESET
//   timeout_cnt  out  timeouts in this run, saturating at 255
// ----------------------------------------------------------------------------
module i2c_init_sequencer #(
    parameter int unsigned AW               = 4,
    parameter int unsigned WAIT_CYCLES      = 8000,
    parameter int unsigned GAP_CYCLES       = 64,
    parameter int unsigned ABORT_ON_TIMEOUT = 0
) (
    input  logic                        CLOCK,
    input  logic                        RESET,
    input  logic                        start,
    input  logic [AW:0]                 tbl_count,
    output logic [AW-1:0]               tbl_index,
    input  logic [15:0]                 tbl_data,
    i2c_init_sequencer_if.master        bus,
    output logic                        busy,
    output logic                        done,
    output logic                        error,
    output logic [7:0]                  timeout_cnt
);

    localparam int unsigned DEPTH     = 1 << AW;
    localparam int unsigned CNT_MAX   = (WAIT_CYCLES > GAP_CYCLES) ? WAIT_CYCLES : GAP_CYCLES;
    localparam int unsigned CW        = $clog2(CNT_MAX + 1);
    localparam logic [AW:0]   MAX_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   COUNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] IDX_ONE   = AW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic          ABORT     = (ABORT_ON_TIMEOUT != 0);

    localparam logic [7:0] A_CALL = 8'd0;
    localparam logic [7:0] A_ADDR = 8'd1;
    localparam logic [7:0] A_DATA = 8'd2;

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        WR_ADDR,
        WR_DATA,
        WR_CALL,
        WAIT,
        CLR_CALL,
        GAP,
        FINISH
    } state_t;

    state_t          state;
    logic [AW-1:0]   idx;
    logic [AW:0]     n_lat;
    logic [7:0]      data_byte;
    logic [CW-1:0]   cnt;
    logic            timed_out;
    logic            av_strobe;
    logic [7:0]      av_addr;
    logic [31:0]     av_wdata;
    logic            last_entry;

    assign last_entry = ({1'b0, idx} == (n_lat - COUNT_ONE));

    assign tbl_index          = idx;
    assign bus.avm_chipselect = av_strobe;
    assign bus.avm_write      = av_strobe;
    assign bus.avm_address    = av_addr;
    assign bus.avm_writedata  = av_wdata;

    // Bus outputs are loaded on the transition INTO each write state so the
    // strobe lines up with that state's cycle (LOAD -> WR_ADDR puts the first
    // write two cycles after the start cycle).
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state       <= IDLE;
            idx         <= '0;
            n_lat       <= '0;
            data_byte   <= '0;
            cnt         <= '0;
            timed_out   <= 1'b0;
            av_strobe   <= 1'b0;
            av_addr     <= '0;
            av_wdata    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            timeout_cnt <= '0;
        end else begin
            av_strobe <= 1'b0;
            av_addr   <= '0;
            av_wdata  <= '0;
            done      <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        idx         <= '0;
                        error       <= 1'b0;
                        timeout_cnt <= '0;
                        busy        <= 1'b1;
                        n_lat       <= (tbl_count > MAX_COUNT) ? MAX_COUNT : tbl_count;
                        state       <= (tbl_count == '0) ? FINISH : LOAD;
                    end
                end

                LOAD: begin
                    data_byte <= tbl_data[7:0];
                    av_strobe <= 1'b1;
                    av_addr   <= A_ADDR;
                    av_wdata  <= {24'd0, tbl_data[15:8]};
                    state     <= WR_ADDR;
                end

                WR_ADDR: begin
                    av_strobe <= 1'b1;
                    av_addr   <= A_DATA;
                    av_wdata  <= {24'd0, data_byte};
                    state     <= WR_DATA;
                end

                WR_DATA: begin
                    av_strobe <= 1'b1;
                    av_addr   <= A_CALL;
                    av_wdata  <= 32'h2;
                    state     <= WR_CALL;
                end

                WR_CALL: begin
                    cnt       <= '0;
                    timed_out <= 1'b0;
                    state     <= WAIT;
                end

                WAIT: begin
                    // A done pulse on the expiry cycle takes priority.
                    if (bus.i2c_done) begin
                        av_strobe <= 1'b1;
                        av_addr   <= A_CALL;
                        av_wdata  <= '0;
                        state     <= CLR_CALL;
                    end else if (cnt == WAIT_LAST) begin
                        timed_out <= 1'b1;
                        error     <= 1'b1;
                        if (timeout_cnt != 8'hFF) begin
                            timeout_cnt <= timeout_cnt + 8'd1;
                        end
                        av_strobe <= 1'b1;
                        av_addr   <= A_CALL;
                        av_wdata  <= '0;
                        state     <= CLR_CALL;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                CLR_CALL: begin
                    if ((timed_out && ABORT) || last_entry) begin
                        state <= FINISH;
                    end else begin
                        cnt   <= '0;
                        state <= GAP;
                    end
                end

                GAP: begin
                    if (cnt == GAP_LAST) begin
                        idx   <= idx + IDX_ONE;
                        state <= LOAD;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// ----------------------------------------------------------------------------
// tb_i2c_init_sequencer
//   Two sequencer instances: dut0 keeps the default timing and continues after
//   timeouts; dut1 uses short WAIT/GAP windows and aborts on the first timeout.
//   A small engine model answers iCall=2 after a per-entry delay (0 = never)
//   and adds one stray done pulse a few cycles after each real one. The
//   expected write stream, timeout count and done cycle are derived from the
//   table contents and delays.
// ----------------------------------------------------------------------------
module tb_i2c_init_sequencer;

    localparam int W0 = 8000;
    localparam int G0 = 64;
    localparam int W1 = 100;
    localparam int G1 = 4;

    logic CLOCK = 1'b0;
    logic RESET = 1'b1;

    always #5 CLOCK = ~CLOCK;

    logic [1:0] start = '0;
    logic [4:0] tbl_count [2];
    logic [15:0] tbl [2][16];
    int          ack_delay [2][16];

    logic        busy0, busy1, done0, done1, error0, error1;
    logic [7:0]  tcnt0, tcnt1;
    logic [3:0]  tidx0, tidx1;
    logic [15:0] tdata0, tdata1;
    logic [1:0]  eng_done = '0;

    i2c_init_sequencer_if bus0 ();
    i2c_init_sequencer_if bus1 ();

    assign tdata0 = tbl[0][tidx0];
    assign tdata1 = tbl[1][tidx1];
    assign bus0.i2c_done = eng_done[0];
    assign bus1.i2c_done = eng_done[1];

    i2c_init_sequencer #(
        .AW(4), .WAIT_CYCLES(W0), .GAP_CYCLES(G0), .ABORT_ON_TIMEOUT(0)
    ) dut0 (
        .CLOCK(CLOCK), .RESET(RESET), .start(start[0]), .tbl_count(tbl_count[0]),
        .tbl_index(tidx0), .tbl_data(tdata0), .bus(bus0),
        .busy(busy0), .done(done0), .error(error0), .timeout_cnt(tcnt0)
    );

    i2c_init_sequencer #(
        .AW(4), .WAIT_CYCLES(W1), .GAP_CYCLES(G1), .ABORT_ON_TIMEOUT(1)
    ) dut1 (
        .CLOCK(CLOCK), .RESET(RESET), .start(start[1]), .tbl_count(tbl_count[1]),
        .tbl_index(tidx1), .tbl_data(tdata1), .bus(bus1),
        .busy(busy1), .done(done1), .error(error1), .timeout_cnt(tcnt1)
    );

    logic [1:0]       m_cs, m_wr, busy, done, error;
    logic [1:0][7:0]  m_addr, tcnt;
    logic [1:0][31:0] m_data;
    logic [1:0][3:0]  tidx;
    assign m_cs   = {bus1.avm_chipselect, bus0.avm_chipselect};
    assign m_wr   = {bus1.avm_write, bus0.avm_write};
    assign m_addr = {bus1.avm_address, bus0.avm_address};
    assign m_data = {bus1.avm_writedata, bus0.avm_writedata};
    assign busy   = {busy1, busy0};
    assign done   = {done1, done0};
    assign error  = {error1, error0};
    assign tcnt   = {tcnt1, tcnt0};
    assign tidx   = {tidx1, tidx0};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor + engine model, evaluated on every falling edge.
    int          cyc = 0;
    int          first_wr_cyc = 0;
    int          pend_cnt [2];
    int          stray_cnt [2];
    int          call_no [2];
    logic [42:0] act_q [$];
    logic [42:0] exp_q [$];

    initial begin
        for (int i = 0; i < 2; i++) begin
            pend_cnt[i]  = 0;
            stray_cnt[i] = 0;
            call_no[i]   = 0;
        end
        forever begin
            @(negedge CLOCK);
            cyc++;
            for (int i = 0; i < 2; i++) begin
                eng_done[i] = 1'b0;
                if (m_cs[i] || m_wr[i]) begin
                    if (act_q.size() == 0) first_wr_cyc = cyc;
                    act_q.push_back({1'(i), m_cs[i], m_wr[i], m_addr[i], m_data[i]});
                end
                if (RESET) begin
                    pend_cnt[i]  = 0;
                    stray_cnt[i] = 0;
                end
                if (stray_cnt[i] != 0) begin
                    stray_cnt[i]--;
                    if (stray_cnt[i] == 0) eng_done[i] = 1'b1;
                end
                if (pend_cnt[i] != 0) begin
                    pend_cnt[i]--;
                    if (pend_cnt[i] == 0) begin
                        eng_done[i]  = 1'b1;
                        stray_cnt[i] = 3;
                    end
                end
                if (m_cs[i] && m_wr[i] && m_addr[i] == 8'd0 && m_data[i] == 32'd2) begin
                    pend_cnt[i] = (call_no[i] < 16) ? ack_delay[i][call_no[i]] : 0;
                    call_no[i]++;
                end
            end
        end
    end

    task automatic tick;
        @(negedge CLOCK);
        #1;
    endtask

    function automatic logic [63:0] outs(input int i);
        return {7'd0, m_cs[i], m_wr[i], m_addr[i], m_data[i], busy[i], done[i],
                error[i], tcnt[i], tidx[i]};
    endfunction

    // Expected behaviour from the table: each entry costs LOAD + 3 writes +
    // wait + clear (5 + wait cycles), entries are separated by the gap, and
    // done is seen two cycles after the FINISH-bound path starts counting.
    task automatic model(input int i, input int n_raw, output int done_at, output int n_to);
        int n, w, g, d, acc;
        bit to, abort;
        n     = (n_raw > 16) ? 16 : n_raw;
        w     = (i == 1) ? W1 : W0;
        g     = (i == 1) ? G1 : G0;
        abort = (i == 1);
        exp_q.delete();
        n_to = 0;
        acc  = 0;
        for (int e = 0; e < n; e++) begin
            d  = ack_delay[i][e];
            to = (d == 0) || (d > w);
            exp_q.push_back({1'(i), 2'b11, 8'd1, 24'd0, tbl[i][e][15:8]});
            exp_q.push_back({1'(i), 2'b11, 8'd2, 24'd0, tbl[i][e][7:0]});
            exp_q.push_back({1'(i), 2'b11, 8'd0, 32'd2});
            exp_q.push_back({1'(i), 2'b11, 8'd0, 32'd0});
            acc += 5 + (to ? w : d);
            if (to) n_to++;
            if ((to && abort) || e == n - 1) break;
            acc += g;
        end
        done_at = acc + 2;
    endtask

    task automatic run(input int i, input int n, input bit spur);
        int  exp_done, exp_to, k, c0, spur_at, lim;
        bit  seen;
        model(i, n, exp_done, exp_to);
        spur_at = (spur && exp_done >= 6) ? $urandom_range(3, exp_done - 2) : 0;
        act_q.delete();
        call_no[i]   = 0;
        pend_cnt[i]  = 0;
        stray_cnt[i] = 0;
        start[i]     = 1'b1;
        tbl_count[i] = 5'(n);
        c0   = cyc;
        k    = 0;
        seen = 1'b0;
        while (!seen && k < exp_done + 200) begin
            tick;
            k++;
            start[i] = (k == spur_at);
            tbl_count[i] = 5'($urandom);
            if (k == 1) check("busy_after_start", busy[i], 1);
            if (done[i]) seen = 1'b1;
        end
        check("done_cycle", k, exp_done);
        check("busy_at_done", busy[i], 0);
        check("error", error[i], (exp_to != 0));
        check("timeout_cnt", tcnt[i], exp_to);
        tick;
        check("done_one_cycle", done[i], 0);
        check("n_writes", act_q.size(), exp_q.size());
        for (int j = 0; j < exp_q.size() && j < act_q.size(); j++)
            check("write", act_q[j], exp_q[j]);
        if (act_q.size() != 0 && exp_q.size() != 0)
            check("first_write_latency", first_wr_cyc - c0, 2);
    endtask

    task automatic fill(input int i, input int mode);
        for (int e = 0; e < 16; e++) begin
            tbl[i][e] = 16'($urandom);
            if (mode == 0) begin
                ack_delay[i][e] = $urandom_range(1, 150);
            end else begin
                case ($urandom_range(0, 3))
                    0:       ack_delay[i][e] = 0;
                    1:       ack_delay[i][e] = W1;
                    2:       ack_delay[i][e] = W1 + 1;
                    default: ack_delay[i][e] = $urandom_range(1, W1);
                endcase
            end
        end
    endtask

    initial begin
        int k;
        for (int i = 0; i < 2; i++) begin
            tbl_count[i] = '0;
            for (int e = 0; e < 16; e++) begin
                tbl[i][e]       = '0;
                ack_delay[i][e] = 1;
            end
        end

        RESET = 1'b1;
        repeat (3) tick;
        check("reset_outputs_dut0", outs(0), 0);
        check("reset_outputs_dut1", outs(1), 0);
        RESET = 1'b0;
        repeat (3) tick;
        check("no_write_after_reset", act_q.size(), 0);

        // Two entries, engine answers after 3664 cycles.
        tbl[0][0] = 16'h1234; tbl[0][1] = 16'h5678;
        ack_delay[0][0] = 3664; ack_delay[0][1] = 3664;
        run(0, 2, 1'b0);

        // Empty table: done two cycles after start, no writes.
        run(0, 0, 1'b0);

        // Entry 0 never acked; continue mode runs entries 1-2; start during WAIT.
        tbl[0][2] = 16'h9abc;
        ack_delay[0][0] = 0; ack_delay[0][1] = 400; ack_delay[0][2] = 400;
        run(0, 3, 1'b1);

        // Abort mode: entry 0 never acked, sequence ends after its iCall clear.
        fill(1, 1);
        ack_delay[1][0] = 0; ack_delay[1][1] = 30; ack_delay[1][2] = 30;
        run(1, 3, 1'b0);

        // Done on the expiry cycle wins; one cycle later is a timeout.
        ack_delay[1][0] = W1; ack_delay[1][1] = W1 + 1; ack_delay[1][2] = 30;
        run(1, 3, 1'b1);
        ack_delay[1][0] = W1; ack_delay[1][1] = 20;
        run(1, 2, 1'b0);

        // Reset while waiting: everything drops at once, no iCall clear.
        fill(0, 0);
        ack_delay[0][0] = 0;
        act_q.delete();
        call_no[0] = 0;
        start[0] = 1'b1;
        tbl_count[0] = 5'd3;
        tick;
        start[0] = 1'b0;
        k = 0;
        while (act_q.size() < 3 && k < 20) begin
            tick;
            k++;
        end
        repeat (30) tick;
        RESET = 1'b1;
        tick;
        check("reset_in_wait_outputs", outs(0), 0);
        RESET = 1'b0;
        repeat (10) tick;
        check("reset_in_wait_writes", act_q.size(), 3);
        ack_delay[0][0] = 120;
        run(0, 3, 1'b0);

        // Randomized tables, counts (including >16) and engine delays.
        for (int r = 0; r < 4; r++) begin
            fill(0, 0);
            run(0, $urandom_range(0, 31), 1'b1);
        end
        for (int r = 0; r < 8; r++) begin
            fill(1, 1);
            run(1, $urandom_range(0, 20), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
